parking_gate_controller: RTL and testbench
==========================================

# parking_gate_controller

Downstream stage of the keypad/motion-sensor unlock logic. Consumes per-lane unlock requests and drives the entry and exit barrier motors through a timed raise/open/lower sequence. Tracks lot occupancy from the pass sensors and refuses entry when the lot is full. Occupancy and full/empty status go to the display and billing stages.

## Interface
Parameters:
- CAPACITY, 16: number of parking slots; minimum 1.
- MOVE_CYCLES, 50: cycles the barrier motor runs for a full raise or a full lower; minimum 1.
- TIMEOUT_CYCLES, 1000: cycles a gate stays OPEN with no car passing before auto-close (only with PARKING_TIMEOUT_EN); minimum 1.
- CNT_W, $clog2(CAPACITY+1): occupancy width, derived; never overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- unlock_in  in  1  entry-lane unlock level from the keypad stage.
- unlock_out  in  1  exit-lane unlock level from the keypad stage.
- pass_in  in  1  entry beam sensor; high while a car breaks the beam.
- pass_out  in  1  exit beam sensor; high while a car breaks the beam.
- motor_up_in / motor_down_in  out  1 each  entry motor drive.
- motor_up_out / motor_down_out  out  1 each  exit motor drive.
- gate_open_in / gate_open_out  out  1 each  high in the OPEN state.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- denied_in  out  1  one-cycle pulse when an entry request is refused because the lot is full.

## Operation
- Edge detection: unlock_* and pass_* are registered each cycle.
  - A request is the rising edge of unlock_*.
  - A pass event is the falling edge of pass_*, meaning the car has cleared the beam.
- Each gate runs its own FSM with states CLOSED, RAISE, OPEN, LOWER.
  - CLOSED: on a request go to RAISE and load a move counter with MOVE_CYCLES-1.
    - Entry exception: if full is high, stay CLOSED and pulse denied_in.
    - Exit has no full/empty gating, so a car already inside can always leave.
  - RAISE: motor_up high. Count down; at 0 go to OPEN.
  - OPEN: gate_open high.
    - On a pass event go to LOWER and reload the move counter.
    - Requests are ignored in OPEN.
  - LOWER: motor_down high. Count down; at 0 go to CLOSED.
    - A pass_* rising edge (car under the barrier) aborts lowering: go to RAISE with the move counter loaded with MOVE_CYCLES-1.
- Requests arriving in RAISE or LOWER are dropped; they are not queued.
- Motor outputs are one-hot per gate: up and down are never both high.
- Occupancy is updated only by pass events seen in OPEN.
  - Entry pass: +1, saturating at CAPACITY.
  - Exit pass: -1, saturating at 0.
  - Both in the same cycle: no net change.
- full and empty are registered and consistent with occupancy in the same cycle.

## Timing
- Reset (rst_n low, asynchronous): both FSMs CLOSED, counters 0, occupancy 0, empty=1, full=0, every other output 0. Edge-detect registers clear to 0.
- Reset asserted mid-motion stops the motors immediately; the barrier is treated as closed after release.
- Request edge sampled at edge N:
  - motor_up high from N+1 for exactly MOVE_CYCLES cycles.
  - gate_open high from N+1+MOVE_CYCLES.
- Pass falling edge sampled at edge M: occupancy updates and motor_down goes high, both from M+1.
- denied_in is high for exactly cycle N+1.
- full is evaluated on the registered occupancy. A request in the same cycle as an exit pass that frees a slot is still denied.

## Configuration
- PARKING_TIMEOUT_EN defined:
  - In OPEN, a timer counts cycles with no pass event.
  - After TIMEOUT_CYCLES cycles the gate goes to LOWER with no occupancy change.
  - The timer clears on entering OPEN.
- PARKING_TIMEOUT_EN undefined: OPEN holds indefinitely until a pass event; no timer logic is built.

## Structure
- Shared package parking_pkg holds:
  - the gate_state_t enum (CLOSED, RAISE, OPEN, LOWER);
  - the default MOVE_CYCLES and TIMEOUT_CYCLES constants.
- Sub-module gate_fsm, instantiated twice (entry and exit):
  - contains the edge detectors, move counter, optional timeout timer and motor decode;
  - exports a pass_evt pulse that the top uses for occupancy.
- The top holds the occupancy counter, full/empty flags and the deny logic.

## Test plan
All scenarios use CAPACITY=2, MOVE_CYCLES=4, TIMEOUT_CYCLES=8.
- Entry cycle: unlock_in rises, then pass_in pulses while OPEN
  -> motor_up_in high 4 cycles, gate_open_in high, occupancy 0→1, motor_down_in high 4 cycles, then CLOSED.
- Fill then deny: two complete entries, then a third unlock_in
  -> full=1, denied_in one-cycle pulse, motor_up_in stays 0.
- Simultaneous passes at occupancy 1: entry and exit pass events in the same cycle
  -> occupancy stays 1.
- Reopen: pass_in rises during LOWER
  -> state RAISE next cycle, motor_down_in drops, motor_up_in high 4 cycles.
- Timeout, PARKING_TIMEOUT_EN defined: unlock_out with no pass
  -> OPEN for 8 cycles, then LOWER, occupancy unchanged.
  - Same stimulus with the macro undefined -> gate stays OPEN.
- Reset mid-RAISE: rst_n low
  -> all motor outputs 0 immediately; occupancy 0, empty=1 after release.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    RAISE  = 2'd1,
    OPEN   = 2'd2,
    LOWER  = 2'd3
  } gate_state_t;

  localparam int DEFAULT_MOVE_CYCLES    = 50;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/gate_fsm.sv
// One barrier: edge detectors, raise/open/lower sequencing and motor drive.
// PARKING_TIMEOUT_EN adds an idle timer that auto-lowers an unused open gate.
module gate_fsm
  import parking_pkg::*;
#(
  parameter int MOVE_CYCLES    = DEFAULT_MOVE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic unlock,
  input  logic pass,
  input  logic inhibit,
  output logic motor_up,
  output logic motor_down,
  output logic gate_open,
  output logic req_evt,
  output logic pass_evt
);

  localparam int MOVE_W = $clog2(MOVE_CYCLES + 1);
  localparam logic [MOVE_W-1:0] MOVE_LOAD = MOVE_W'(MOVE_CYCLES - 1);

  gate_state_t       state;
  logic [MOVE_W-1:0] move_cnt;
  logic              unlock_q;
  logic              pass_q;
  logic              req;
  logic              pass_fall;
  logic              pass_rise;
  logic              timeout;

  assign req       = unlock & ~unlock_q;
  assign pass_fall = ~pass & pass_q;
  assign pass_rise = pass & ~pass_q;
  assign req_evt   = req && (state == CLOSED);
  assign pass_evt  = pass_fall && (state == OPEN);

`ifdef PARKING_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] idle_cnt;

  assign timeout = (state == OPEN) && (idle_cnt == TMR_LAST);

  // Held at zero outside OPEN, so every entry into OPEN starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != OPEN) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so the edge detectors compare this cycle's input against last cycle's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLOSED;
      move_cnt   <= '0;
      unlock_q   <= 1'b0;
      pass_q     <= 1'b0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      gate_open  <= 1'b0;
    end else begin
      unlock_q <= unlock;
      pass_q   <= pass;
      case (state)
        CLOSED: begin
          if (req && !inhibit) begin
            state    <= RAISE;
            move_cnt <= MOVE_LOAD;
            motor_up <= 1'b1;
          end
        end
        RAISE: begin
          if (move_cnt == '0) begin
            state     <= OPEN;
            motor_up  <= 1'b0;
            gate_open <= 1'b1;
          end else begin
            move_cnt <= move_cnt - 1'b1;
          end
        end
        OPEN: begin
          if (pass_fall || timeout) begin
            state      <= LOWER;
            move_cnt   <= MOVE_LOAD;
            gate_open  <= 1'b0;
            motor_down <= 1'b1;
          end
        end
        LOWER: begin
          // A car breaking the beam under a descending barrier reverses it.
          if (pass_rise) begin
            state      <= RAISE;
            move_cnt   <= MOVE_LOAD;
            motor_down <= 1'b0;
            motor_up   <= 1'b1;
          end else if (move_cnt == '0) begin
            state      <= CLOSED;
            motor_down <= 1'b0;
          end else begin
            move_cnt <= move_cnt - 1'b1;
          end
        end
        default: begin
          state      <= CLOSED;
          motor_up   <= 1'b0;
          motor_down <= 1'b0;
          gate_open  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier controller with lot occupancy tracking and full-lot denial.
// PARKING_TIMEOUT_EN enables auto-close of gates left open with no car passing.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY       = 16,
  parameter int MOVE_CYCLES    = DEFAULT_MOVE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             unlock_in,
  input  logic             unlock_out,
  input  logic             pass_in,
  input  logic             pass_out,
  output logic             motor_up_in,
  output logic             motor_down_in,
  output logic             motor_up_out,
  output logic             motor_down_out,
  output logic             gate_open_in,
  output logic             gate_open_out,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             denied_in
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic             entry_req;
  logic             entry_pass;
  logic             exit_pass;
  logic             unused_exit_req;
  logic [CNT_W-1:0] occ_next;

  gate_fsm #(
    .MOVE_CYCLES   (MOVE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_entry (
    .clk       (clk),
    .rst_n     (rst_n),
    .unlock    (unlock_in),
    .pass      (pass_in),
    .inhibit   (full),
    .motor_up  (motor_up_in),
    .motor_down(motor_down_in),
    .gate_open (gate_open_in),
    .req_evt   (entry_req),
    .pass_evt  (entry_pass)
  );

  // Exit is never inhibited: a car already inside can always leave.
  gate_fsm #(
    .MOVE_CYCLES   (MOVE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_exit (
    .clk       (clk),
    .rst_n     (rst_n),
    .unlock    (unlock_out),
    .pass      (pass_out),
    .inhibit   (1'b0),
    .motor_up  (motor_up_out),
    .motor_down(motor_down_out),
    .gate_open (gate_open_out),
    .req_evt   (unused_exit_req),
    .pass_evt  (exit_pass)
  );

  // NOTE: the default assignment first guarantees no latch on any path.
  always_comb begin
    occ_next = occupancy;
    if (entry_pass && !exit_pass && occupancy != CAP) begin
      occ_next = occupancy + 1'b1;
    end else if (exit_pass && !entry_pass && occupancy != '0) begin
      occ_next = occupancy - 1'b1;
    end
  end

  // Flags are derived from occ_next so they always match the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      denied_in <= 1'b0;
    end else begin
      occupancy <= occ_next;
      full      <= (occ_next == CAP);
      empty     <= (occ_next == '0);
      denied_in <= entry_req && full;
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor pops and compares.
module tb_parking_gate_controller;

  localparam int CAPACITY = 2;
  localparam int MOVE     = 4;
  localparam int TMO      = 8;

  typedef struct {
    int          at_edge;
    logic [10:0] vec;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       unlock_in = 1'b0, unlock_out = 1'b0, pass_in = 1'b0, pass_out = 1'b0;
  logic       motor_up_in, motor_down_in, motor_up_out, motor_down_out;
  logic       gate_open_in, gate_open_out, full, empty, denied_in;
  logic [1:0] occupancy;

  logic x_up_i, x_dn_i, x_op_i, x_up_o, x_dn_o, x_op_o, x_den, x_full, x_empty;
  logic [1:0] x_occ;

  exp_t        q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          mon_en = 1'b0;
  logic [10:0] dvec;

  parking_gate_controller #(
    .CAPACITY      (CAPACITY),
    .MOVE_CYCLES   (MOVE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .unlock_in     (unlock_in),
    .unlock_out    (unlock_out),
    .pass_in       (pass_in),
    .pass_out      (pass_out),
    .motor_up_in   (motor_up_in),
    .motor_down_in (motor_down_in),
    .motor_up_out  (motor_up_out),
    .motor_down_out(motor_down_out),
    .gate_open_in  (gate_open_in),
    .gate_open_out (gate_open_out),
    .occupancy     (occupancy),
    .full          (full),
    .empty         (empty),
    .denied_in     (denied_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dvec = {motor_up_in, motor_down_in, gate_open_in, motor_up_out, motor_down_out,
                 gate_open_out, denied_in, full, empty, occupancy};

  function automatic logic [10:0] xvec();
    return {x_up_i, x_dn_i, x_op_i, x_up_o, x_dn_o, x_op_o, x_den, x_full, x_empty, x_occ};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic push(input int e, input string nm);
    exp_t t;
    t.at_edge = e;
    t.vec     = xvec();
    t.name    = nm;
    q.push_back(t);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_occ(input logic [1:0] v);
    x_occ   = v;
    x_full  = (v == 2'(CAPACITY));
    x_empty = (v == 2'd0);
  endtask

  task automatic reset_expect();
    {x_up_i, x_dn_i, x_op_i, x_up_o, x_dn_o, x_op_o, x_den} = '0;
    set_occ(2'd0);
  endtask

  // Request edge sampled at edge n: up from n, open from n+MOVE.
  task automatic open_gates(input bit gi, input bit go, input string nm, output int n);
    unlock_in  = gi;
    unlock_out = go;
    n = cyc + 1;
    if (gi) x_up_i = 1'b1;
    if (go) x_up_o = 1'b1;
    push(n, {nm, " raise"});
    if (gi) begin x_up_i = 1'b0; x_op_i = 1'b1; end
    if (go) begin x_up_o = 1'b0; x_op_o = 1'b1; end
    push(n + MOVE, {nm, " open"});
    step(1);
    unlock_in  = 1'b0;
    unlock_out = 1'b0;
    step(MOVE + 1);
  endtask

  task automatic pass_gates(input bit gi, input bit go, input logic [1:0] occ_after,
                            input string nm);
    int m;
    pass_in  = gi;
    pass_out = go;
    step(2);
    pass_in  = 1'b0;
    pass_out = 1'b0;
    m = cyc + 1;
    if (gi) begin x_op_i = 1'b0; x_dn_i = 1'b1; end
    if (go) begin x_op_o = 1'b0; x_dn_o = 1'b1; end
    set_occ(occ_after);
    push(m, {nm, " lower"});
    x_dn_i = 1'b0;
    x_dn_o = 1'b0;
    push(m + MOVE, {nm, " closed"});
    step(MOVE + 2);
  endtask

  // Monitor: every change of the output vector must match the next expectation.
  initial begin
    logic [10:0] prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = dvec;
      end else if (dvec !== prev) begin
        if (q.size() == 0) begin
          check("unexpected output change", 32'(dvec), 32'(prev));
        end else begin
          e = q.pop_front();
          check({e.name, " edge"}, cyc, e.at_edge);
          check({e.name, " value"}, 32'(dvec), 32'(e.vec));
        end
        prev = dvec;
      end
    end
  end

  initial begin
    int n, m, r;
    reset_expect();
    step(2);
    rst_n = 1'b1;
    check("reset vector", 32'(dvec), 32'(xvec()));
    mon_en = 1'b1;
    step(1);

    open_gates(1'b1, 1'b0, "entry1", n);
    pass_gates(1'b1, 1'b0, 2'd1, "entry1");
    open_gates(1'b1, 1'b0, "entry2", n);
    pass_gates(1'b1, 1'b0, 2'd2, "entry2");

    // Lot full: request refused with a one-cycle pulse and no motion.
    unlock_in = 1'b1;
    n = cyc + 1;
    x_den = 1'b1;
    push(n, "deny pulse");
    x_den = 1'b0;
    push(n + 1, "deny end");
    step(2);
    unlock_in = 1'b0;
    step(2);
    check("deny no raise", 32'(motor_up_in), 32'd0);

    open_gates(1'b0, 1'b1, "exit1", n);
    pass_gates(1'b0, 1'b1, 2'd1, "exit1");

    open_gates(1'b1, 1'b1, "both", n);
    pass_gates(1'b1, 1'b1, 2'd1, "both");

    // Reopen: beam broken again while lowering; final pass saturates at capacity.
    open_gates(1'b1, 1'b0, "reopen", n);
    pass_in = 1'b1;
    step(2);
    pass_in = 1'b0;
    m = cyc + 1;
    x_op_i = 1'b0;
    x_dn_i = 1'b1;
    set_occ(2'd2);
    push(m, "reopen lower");
    step(2);
    pass_in = 1'b1;
    r = cyc + 1;
    x_dn_i = 1'b0;
    x_up_i = 1'b1;
    push(r, "reopen raise");
    x_up_i = 1'b0;
    x_op_i = 1'b1;
    push(r + MOVE, "reopen open");
    step(MOVE + 2);
    pass_in = 1'b0;
    m = cyc + 1;
    x_op_i = 1'b0;
    x_dn_i = 1'b1;
    push(m, "saturate lower");
    x_dn_i = 1'b0;
    push(m + MOVE, "saturate closed");
    step(MOVE + 2);

    // Entry request in the same cycle an exit pass frees a slot is still denied.
    open_gates(1'b0, 1'b1, "exit2", n);
    pass_out = 1'b1;
    step(2);
    pass_out  = 1'b0;
    unlock_in = 1'b1;
    m = cyc + 1;
    x_op_o = 1'b0;
    x_dn_o = 1'b1;
    x_den  = 1'b1;
    set_occ(2'd1);
    push(m, "late deny");
    x_den = 1'b0;
    push(m + 1, "late deny end");
    x_dn_o = 1'b0;
    push(m + MOVE, "exit2 closed");
    step(1);
    unlock_in = 1'b0;
    step(MOVE + 2);

    open_gates(1'b0, 1'b1, "timeout", n);
`ifdef PARKING_TIMEOUT_EN
    x_op_o = 1'b0;
    x_dn_o = 1'b1;
    push(n + MOVE + TMO, "timeout lower");
    x_dn_o = 1'b0;
    push(n + 2 * MOVE + TMO, "timeout closed");
    step(TMO + MOVE + 2);
    check("timeout occupancy", 32'(occupancy), 32'd1);
`else
    step(TMO + MOVE + 2);
    check("hold open", 32'(gate_open_out), 32'd1);
    pass_gates(1'b0, 1'b1, 2'd0, "hold exit");
`endif

    // Reset while raising stops the motor at once.
    unlock_in = 1'b1;
    n = cyc + 1;
    x_up_i = 1'b1;
    push(n, "rst raise");
    step(2);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst motors off", 32'({motor_up_in, motor_down_in, motor_up_out, motor_down_out}), 32'd0);
    check("rst occupancy", 32'(occupancy), 32'd0);
    unlock_in = 1'b0;
    step(2);
    rst_n = 1'b1;
    reset_expect();
    step(1);
    check("post reset vector", 32'(dvec), 32'(xvec()));
    check("post reset empty", 32'(empty), 32'd1);
    mon_en = 1'b1;
    step(5);

    check("expectations drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
